uart_frame_rx: RTL and testbench

- Next-generation framed UART receiver for inter-board links: parametrised payload width, sync byte, CRC-16 check, inter-byte gap timeout and link-loss timeout.
- Adds a one-cycle valid strobe, saturating error/frame statistics and a true asynchronous reset.
- Sits between the existing uart_rx byte receiver (instantiated inside, ce_16 = baud_clock) and control logic that consumes a BYTES*8 word.

---
 rtl/uart_frame_pkg.sv | 26 ++
 rtl/crc16_modbus.sv | 39 +++
 rtl/uart_rx.sv | 71 +++++++
 rtl/uart_frame_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_frame_rx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared state encoding, CRC constants and saturating arithmetic for the
// framed UART receiver and its CRC engine.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PAYLOAD = 3'd1,
      ST_CRC_LO  = 3'd2,
      ST_CRC_HI  = 3'd3,
      ST_CHECK   = 3'd4
   } state_t;

   localparam logic [15:0] CRC16_POLY = 16'hA001;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/crc16_modbus.sv
// Byte-serial CRC-16/MODBUS engine (reflected polynomial), one byte per clock.
module crc16_modbus
   import uart_frame_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr,
   input  logic        ena,
   input  logic [7:0]  din,
   output logic [15:0] crc
);

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++) begin
         if (r[0]) begin
            r = (r >> 1) ^ CRC16_POLY;
         end else begin
            r = r >> 1;
         end
      end
      return r;
   endfunction

   // CRC register: preset on clr, advance one byte on ena
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crc <= CRC16_INIT;
      end else if (clr) begin
         crc <= CRC16_INIT;
      end else if (ena) begin
         crc <= crc_byte(crc, din);
      end else begin
         crc <= crc;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 byte receiver: two-flop input synchroniser, mid-bit sampling on a 16x
// clock enable, one-cycle new_rx_data strobe per byte with a valid stop bit.
module uart_rx (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce_16,
   input  logic       ser_in,
   output logic [7:0] rx_data,
   output logic       new_rx_data
);

   logic [1:0] sync_r;
   logic       busy_r;
   logic [3:0] tick_r;
   logic [3:0] bit_r;
   logic [7:0] shift_r;
   logic       rx_s;

   assign rx_s = sync_r[1];

   // Metastability guard on the serial line
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], ser_in};
      end
   end

   // Bit timing: tick 7 of each 16-tick cell is the bit centre
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_r      <= 1'b0;
         tick_r      <= 4'd0;
         bit_r       <= 4'd0;
         shift_r     <= 8'h00;
         rx_data     <= 8'h00;
         new_rx_data <= 1'b0;
      end else begin
         new_rx_data <= 1'b0;
         if (ce_16) begin
            if (!busy_r) begin
               if (!rx_s) begin
                  busy_r <= 1'b1;
                  tick_r <= 4'd0;
                  bit_r  <= 4'd0;
               end
            end else begin
               tick_r <= tick_r + 4'd1;
               if (tick_r == 4'd7) begin
                  bit_r <= bit_r + 4'd1;
                  if (bit_r == 4'd0) begin
                     if (rx_s) begin
                        busy_r <= 1'b0;
                     end
                  end else if (bit_r < 4'd9) begin
                     shift_r <= {rx_s, shift_r[7:1]};
                  end else begin
                     busy_r <= 1'b0;
                     if (rx_s) begin
                        rx_data     <= shift_r;
                        new_rx_data <= 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/uart_frame_rx.sv
// Framed UART receiver: sync byte, fixed-length payload, CRC-16 trailer,
// inter-byte gap abort, link-loss fallback and saturating statistics.
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int unsigned        BYTES       = 4,
   parameter logic [7:0]         SYNC_BYTE   = 8'hA5,
   parameter int unsigned        GAP_TICKS   = 255,
   parameter int unsigned        LINK_TICKS  = 15000,
   parameter logic [BYTES*8-1:0] DEFAULT_OUT = {(BYTES*8){1'b0}}
)(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               baud_clock,
   input  logic               rx_i,
   output logic [BYTES*8-1:0] data_o,
   output logic               valid_o,
   output logic               no_comm_o,
   output logic [15:0]        frame_cnt_o,
   output logic [15:0]        crc_err_cnt_o,
   output logic [15:0]        gap_err_cnt_o
);

   localparam int unsigned      WIDTH    = BYTES * 8;
   localparam int unsigned      IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int unsigned      GAP_W    = ($clog2(GAP_TICKS + 1) > 8) ? $clog2(GAP_TICKS + 1) : 8;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
   localparam logic [15:0]      LINK_MAX = 16'(LINK_TICKS);

   state_t             state_r, state_nxt_s;
   logic [7:0]         rx_byte_s;
   logic               rx_strobe_s;
   logic [15:0]        crc_s;
   logic               crc_clr_s, crc_ena_s, store_s;
   logic               good_s, bad_s, gap_abort_s, gap_hit_s, in_frame_s;
   logic [IDX_W-1:0]   idx_r;
   logic [GAP_W-1:0]   gap_r;
   logic [15:0]        link_r;
   logic [WIDTH-1:0]   data_r;

   uart_rx u_uart_rx (
      .clock       (clk_i),
      .reset       (~rst_ni),
      .ce_16       (baud_clock),
      .ser_in      (rx_i),
      .rx_data     (rx_byte_s),
      .new_rx_data (rx_strobe_s)
   );

   crc16_modbus u_crc (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr    (crc_clr_s),
      .ena    (crc_ena_s),
      .din    (rx_byte_s),
      .crc    (crc_s)
   );

   assign in_frame_s = (state_r == ST_PAYLOAD) || (state_r == ST_CRC_LO) || (state_r == ST_CRC_HI);
   assign gap_hit_s  = baud_clock && (gap_r == GAP_LAST);

   // Frame state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state; a byte strobe always wins over a gap abort in the same cycle
   always_comb begin
      state_nxt_s = state_r;
      crc_clr_s   = 1'b0;
      crc_ena_s   = 1'b0;
      store_s     = 1'b0;
      good_s      = 1'b0;
      bad_s       = 1'b0;
      gap_abort_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rx_strobe_s && (rx_byte_s == SYNC_BYTE)) begin
               state_nxt_s = ST_PAYLOAD;
               crc_clr_s   = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PAYLOAD, ST_CRC_LO, ST_CRC_HI: begin
            if (rx_strobe_s) begin
               crc_ena_s = 1'b1;
               if (state_r == ST_PAYLOAD) begin
                  store_s     = 1'b1;
                  state_nxt_s = (idx_r == IDX_LAST) ? ST_CRC_LO : ST_PAYLOAD;
               end else if (state_r == ST_CRC_LO) begin
                  state_nxt_s = ST_CRC_HI;
               end else begin
                  state_nxt_s = ST_CHECK;
               end
            end else if (gap_hit_s) begin
               state_nxt_s = ST_IDLE;
               gap_abort_s = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_CHECK: begin
            state_nxt_s = ST_IDLE;
            if (crc_s == 16'h0000) begin
               good_s = 1'b1;
            end else begin
               bad_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Payload assembly and inter-byte gap timer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_r  <= {IDX_W{1'b0}};
         data_r <= {WIDTH{1'b0}};
         gap_r  <= {GAP_W{1'b0}};
      end else begin
         if (crc_clr_s) begin
            idx_r <= {IDX_W{1'b0}};
         end else if (store_s) begin
            idx_r                 <= idx_r + IDX_W'(1);
            data_r[idx_r*8 +: 8]  <= rx_byte_s;
         end
         if (!in_frame_s || rx_strobe_s) begin
            gap_r <= {GAP_W{1'b0}};
         end else if (baud_clock) begin
            gap_r <= gap_r + GAP_W'(1);
         end
      end
   end

   // Outputs and link supervision; a good frame beats the saturating tick
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_o        <= DEFAULT_OUT;
         valid_o       <= 1'b0;
         no_comm_o     <= 1'b1;
         link_r        <= 16'd0;
         frame_cnt_o   <= 16'd0;
         crc_err_cnt_o <= 16'd0;
         gap_err_cnt_o <= 16'd0;
      end else begin
         valid_o <= good_s;
         if (good_s) begin
            data_o      <= data_r;
            no_comm_o   <= 1'b0;
            link_r      <= 16'd0;
            frame_cnt_o <= sat_inc16(frame_cnt_o);
         end else if (baud_clock && (link_r != LINK_MAX)) begin
            link_r <= link_r + 16'd1;
            if (link_r == LINK_MAX - 16'd1) begin
               data_o    <= DEFAULT_OUT;
               no_comm_o <= 1'b1;
            end
         end
         if (bad_s) begin
            crc_err_cnt_o <= sat_inc16(crc_err_cnt_o);
         end
         if (gap_abort_s) begin
            gap_err_cnt_o <= sat_inc16(gap_err_cnt_o);
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx (BYTES=9): vector table of byte sequences
// plus hand-written gap, link-loss and mid-frame reset sequences.
module tb_uart_frame_rx;

   localparam logic [71:0] PAY = 72'h39_38_37_36_35_34_33_32_31;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        baud_clock = 1'b0;
   logic        rx = 1'b1;
   logic [71:0] data_o;
   logic        valid_o, no_comm_o;
   logic [15:0] frame_cnt_o, crc_err_cnt_o, gap_err_cnt_o;

   int total = 0;
   int passed = 0;
   int vcount = 0;

   typedef struct {
      logic             do_rst;
      int               nb;
      logic [15:0][7:0] seq;
      int               exp_valid;
      logic [15:0]      exp_frames, exp_crc, exp_gap;
      logic             exp_nc;
      logic [71:0]      exp_data;
   } vec_t;

   vec_t vecs[5];

   uart_frame_rx #(
      .BYTES(9), .SYNC_BYTE(8'hA5), .GAP_TICKS(255), .LINK_TICKS(15000), .DEFAULT_OUT(72'h0)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .baud_clock(baud_clock), .rx_i(rx),
      .data_o(data_o), .valid_o(valid_o), .no_comm_o(no_comm_o),
      .frame_cnt_o(frame_cnt_o), .crc_err_cnt_o(crc_err_cnt_o), .gap_err_cnt_o(gap_err_cnt_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) baud_clock <= ~baud_clock;

   always @(negedge clk) if (valid_o) vcount <= vcount + 1;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         repeat (32) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] sync, input logic [7:0] crc_hi);
      send_byte(sync);
      for (int i = 1; i <= 9; i++) send_byte(8'h30 + 8'(i));
      send_byte(8'h37);
      send_byte(crc_hi);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ni = 1'b0;
      repeat (4) @(negedge clk);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic add_byte(input int v, input logic [7:0] b);
      vecs[v].seq[vecs[v].nb] = b;
      vecs[v].nb++;
   endtask

   task automatic add_frame(input int v, input logic [7:0] sync, input logic [7:0] crc_hi);
      add_byte(v, sync);
      for (int i = 1; i <= 9; i++) add_byte(v, 8'h30 + 8'(i));
      add_byte(v, 8'h37);
      add_byte(v, crc_hi);
   endtask

   task automatic setv(input int v, input logic r, input int ev, input logic [15:0] fr,
                       input logic [15:0] ce, input logic [15:0] ge, input logic nc,
                       input logic [71:0] d);
      vecs[v].do_rst = r;     vecs[v].nb = 0;       vecs[v].seq = '0;
      vecs[v].exp_valid = ev; vecs[v].exp_frames = fr;
      vecs[v].exp_crc = ce;   vecs[v].exp_gap = ge;
      vecs[v].exp_nc = nc;    vecs[v].exp_data = d;
   endtask

   initial begin
      int base, b, n;

      // good; bad CRC; good after bad; noise+good+trailing byte; wrong sync
      setv(0, 1'b1, 1, 16'd1, 16'd0, 16'd0, 1'b0, PAY);   add_frame(0, 8'hA5, 8'h4B);
      setv(1, 1'b1, 0, 16'd0, 16'd1, 16'd0, 1'b1, 72'h0); add_frame(1, 8'hA5, 8'h4C);
      setv(2, 1'b0, 1, 16'd1, 16'd1, 16'd0, 1'b0, PAY);   add_frame(2, 8'hA5, 8'h4B);
      setv(3, 1'b1, 1, 16'd1, 16'd0, 16'd0, 1'b0, PAY);
      add_byte(3, 8'h00); add_byte(3, 8'hFF); add_byte(3, 8'h5A);
      add_frame(3, 8'hA5, 8'h4B); add_byte(3, 8'h55);
      setv(4, 1'b0, 0, 16'd1, 16'd0, 16'd0, 1'b0, PAY);   add_frame(4, 8'hA4, 8'h4B);

      do_reset();
      chk("rst_data", data_o, 72'h0);
      chk("rst_valid", {71'h0, valid_o}, 72'h0);
      chk("rst_no_comm", {71'h0, no_comm_o}, 72'h1);
      chk("rst_frames", {56'h0, frame_cnt_o}, 72'h0);
      chk("rst_crc_err", {56'h0, crc_err_cnt_o}, 72'h0);
      chk("rst_gap_err", {56'h0, gap_err_cnt_o}, 72'h0);

      for (int v = 0; v < 5; v++) begin
         if (vecs[v].do_rst) do_reset();
         base = vcount;
         for (int k = 0; k < vecs[v].nb; k++) send_byte(vecs[v].seq[k]);
         repeat (40) @(negedge clk);
         chk($sformatf("v%0d_valid_pulses", v), 72'(vcount - base), 72'(vecs[v].exp_valid));
         chk($sformatf("v%0d_frames", v), {56'h0, frame_cnt_o}, {56'h0, vecs[v].exp_frames});
         chk($sformatf("v%0d_crc_err", v), {56'h0, crc_err_cnt_o}, {56'h0, vecs[v].exp_crc});
         chk($sformatf("v%0d_gap_err", v), {56'h0, gap_err_cnt_o}, {56'h0, vecs[v].exp_gap});
         chk($sformatf("v%0d_no_comm", v), {71'h0, no_comm_o}, {71'h0, vecs[v].exp_nc});
         chk($sformatf("v%0d_data", v), data_o, vecs[v].exp_data);
      end

      // Gap timeout mid-payload, then recovery
      do_reset();
      base = vcount;
      send_byte(8'hA5); send_byte(8'h31); send_byte(8'h32);
      repeat (620) @(negedge clk);
      chk("gap_err_cnt", {56'h0, gap_err_cnt_o}, 72'h1);
      chk("gap_no_valid", 72'(vcount - base), 72'h0);
      send_frame(8'hA5, 8'h4B);
      repeat (40) @(negedge clk);
      chk("gap_next_frames", {56'h0, frame_cnt_o}, 72'h1);
      chk("gap_next_data", data_o, PAY);

      // Link loss exactly LINK_TICKS baud ticks after the good frame
      do_reset();
      fork
         send_frame(8'hA5, 8'h4B);
      join_none
      b = 0;
      while (valid_o !== 1'b1 && b < 8000) begin
         @(negedge clk);
         b++;
      end
      chk("link_valid_seen", {71'h0, valid_o}, 72'h1);
      n = 0;
      while (1) begin
         if (baud_clock) n++;
         if (n == 14999) break;
         @(negedge clk);
      end
      @(negedge clk);
      chk("link_14999_data", data_o, PAY);
      chk("link_14999_no_comm", {71'h0, no_comm_o}, 72'h0);
      while (!baud_clock) @(negedge clk);
      @(negedge clk);
      chk("link_15000_data", data_o, 72'h0);
      chk("link_15000_no_comm", {71'h0, no_comm_o}, 72'h1);

      // Asynchronous reset between payload bytes 3 and 4
      do_reset();
      send_frame(8'hA5, 8'h4B);
      repeat (40) @(negedge clk);
      chk("arst_pre_frames", {56'h0, frame_cnt_o}, 72'h1);
      send_byte(8'hA5); send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
      @(negedge clk);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_frames", {56'h0, frame_cnt_o}, 72'h0);
      chk("arst_no_comm", {71'h0, no_comm_o}, 72'h1);
      chk("arst_data", data_o, 72'h0);
      chk("arst_valid", {71'h0, valid_o}, 72'h0);
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      base = vcount;
      send_frame(8'hA5, 8'h4B);
      repeat (40) @(negedge clk);
      chk("arst_next_frames", {56'h0, frame_cnt_o}, 72'h1);
      chk("arst_next_data", data_o, PAY);
      chk("arst_next_valid", 72'(vcount - base), 72'h1);
      chk("arst_next_crc_err", {56'h0, crc_err_cnt_o}, 72'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
